// File: rtl/muldiv_unit_if.sv
// Request/result bundle for muldiv_unit.
//   master (execute-stage control): drives start/op/a/b, observes busy/done/hi/lo
//   slave  (muldiv_unit):           consumes start/op/a/b, drives busy/done/hi/lo
//   start  request strobe, sampled on posedge cp
//   op     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 NOP
//   a, b   rs / rt operands
//   busy   iterative operation in progress
//   done   one-cycle pulse after HI/LO commit of a MULT/MULTU/DIV/DIVU
//   hi, lo architectural HI/LO registers
interface muldiv_unit_if #(
  parameter int unsigned W = 32
) ();
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with its own HI/LO registers.
// Ports:
//   cp   clock, all state changes on posedge
//   rst  synchronous active-high reset
//   bus  muldiv_unit_if slave modport (start/op/a/b in, busy/done/hi/lo out)
// MULT/MULTU/DIV/DIVU run W iteration cycles plus one sign-fix/commit cycle.
// MTHI/MTLO write HI/LO directly at the accept edge.
module muldiv_unit #(
  parameter int unsigned W = 32
) (
  input logic           cp,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(W) + 1;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e         r_state;
  logic [CW-1:0]  r_cnt;
  // Multiply: {upper partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, quotient/dividend shift register}.
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_opb;     // multiplicand or divisor magnitude
  logic           r_is_div;
  logic           r_div0;
  logic           r_neg_q;   // product or quotient must be negated
  logic           r_neg_r;   // remainder must be negated
  logic           r_busy;
  logic           r_done;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;

  // Operand magnitudes at accept.
  logic         w_signed;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [W-1:0] w_a_mag;
  logic [W-1:0] w_b_mag;

  always_comb begin
    w_signed = (bus.op == OpMult) || (bus.op == OpDiv);
    w_a_neg  = w_signed && bus.a[W-1];
    w_b_neg  = w_signed && bus.b[W-1];
    w_a_mag  = w_a_neg ? -bus.a : bus.a;
    w_b_mag  = w_b_neg ? -bus.b : bus.b;
  end

  // One shift-add step; carry out of the upper half is kept in bit W.
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;

  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : {(W+1){1'b0}});
    w_mul_next = {w_mul_sum, r_acc[W-1:1]};
  end

  // One restoring shift-subtract step. w_div_top is the remainder after the
  // left shift, so it needs one extra bit.
  logic [W:0]     w_div_top;
  logic [W:0]     w_div_diff;
  logic [2*W-1:0] w_div_next;

  always_comb begin
    w_div_top  = r_acc[2*W-1:W-1];
    w_div_diff = w_div_top - {1'b0, r_opb};
    if (!w_div_diff[W]) begin
      w_div_next = {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};
    end else begin
      w_div_next = {r_acc[2*W-2:0], 1'b0};
    end
  end

  // Sign correction applied in FIX.
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;

  always_comb begin
    w_prod = r_neg_q ? -r_acc : r_acc;
    w_quo  = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    w_rem  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            case (bus.op)
              OpMult, OpMultu: begin
                r_acc    <= {{W{1'b0}}, w_b_mag};
                r_opb    <= w_a_mag;
                r_is_div <= 1'b0;
                r_div0   <= 1'b0;
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= 1'b0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_state  <= StRun;
              end
              OpDiv, OpDivu: begin
                r_acc    <= {{W{1'b0}}, w_a_mag};
                r_opb    <= w_b_mag;
                r_is_div <= 1'b1;
                r_div0   <= (bus.b == '0);
                r_neg_q  <= w_a_neg ^ w_b_neg;
                r_neg_r  <= w_a_neg;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_state  <= StRun;
              end
              OpMthi:  r_hi <= bus.a;
              OpMtlo:  r_lo <= bus.a;
              default: ;
            endcase
          end
        end
        StRun: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == CW'(W - 1)) begin
            r_state <= StFix;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StFix: begin
          if (r_is_div) begin
            // With a zero divisor every trial subtract succeeds, so the
            // remainder ends as |a| and its sign fix restores the original a.
            r_lo <= r_div0 ? {W{1'b1}} : w_quo;
            r_hi <= w_rem;
          end else begin
            r_hi <= w_prod[2*W-1:W];
            r_lo <= w_prod[W-1:0];
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  logic cp = 1'b0;
  logic rst;

  always #5 cp = ~cp;

  muldiv_unit_if #(.W(W)) u_if ();

  muldiv_unit #(.W(W)) u_dut (
    .cp  (cp),
    .rst (rst),
    .bus (u_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard of expected {hi, lo} per issued iterative op.
  logic [2*W-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue an iterative op; optionally pulse an MTHI start while busy at
  // busy-cycle ign_at (0 = never). Checks latency, done pulse and results.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh,
                       input logic [W-1:0] el, input int ign_at);
    int cyc;
    logic [2*W-1:0] exp_v;
    @(negedge cp);
    u_if.start = 1'b1;
    u_if.op    = op;
    u_if.a     = a;
    u_if.b     = b;
    sb_q.push_back({eh, el});
    @(negedge cp);
    u_if.start = 1'b0;
    cyc = 0;
    while (u_if.busy && cyc < 100) begin
      cyc++;
      if (cyc == ign_at) begin
        u_if.start = 1'b1;
        u_if.op    = 3'd4;
        u_if.a     = '0;
      end else begin
        u_if.start = 1'b0;
      end
      @(negedge cp);
    end
    u_if.start = 1'b0;
    chk({tag, " busy_cycles"}, 64'(cyc), 64'(W + 1));
    chk({tag, " done"}, 64'(u_if.done), 64'd1);
    chk({tag, " sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      chk({tag, " hi"}, 64'(u_if.hi), 64'(exp_v[2*W-1:W]));
      chk({tag, " lo"}, 64'(u_if.lo), 64'(exp_v[W-1:0]));
    end
    @(negedge cp);
    chk({tag, " done_drop"}, 64'(u_if.done), 64'd0);
  endtask

  initial begin
    int done_seen;
    u_if.start = 1'b0;
    u_if.op    = '0;
    u_if.a     = '0;
    u_if.b     = '0;
    rst        = 1'b1;
    repeat (2) @(negedge cp);
    rst = 1'b0;
    chk("rst busy", 64'(u_if.busy), 64'd0);
    chk("rst done", 64'(u_if.done), 64'd0);
    chk("rst hi", 64'(u_if.hi), 64'd0);
    chk("rst lo", 64'(u_if.lo), 64'd0);

    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
    do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    do_op("div_negb", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0);
    do_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    do_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, 0);
    do_op("divu_by0", 3'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 0);
    do_op("div_by0", 3'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);

    // MTHI then MTLO on consecutive edges.
    @(negedge cp);
    u_if.start = 1'b1;
    u_if.op    = 3'd4;
    u_if.a     = 32'hAAAA_5555;
    @(negedge cp);
    chk("mthi hi", 64'(u_if.hi), 64'hAAAA_5555);
    chk("mthi busy", 64'(u_if.busy), 64'd0);
    chk("mthi done", 64'(u_if.done), 64'd0);
    u_if.op = 3'd5;
    u_if.a  = 32'h0000_1234;
    @(negedge cp);
    u_if.start = 1'b0;
    chk("mtlo lo", 64'(u_if.lo), 64'h0000_1234);
    chk("mtlo hi_hold", 64'(u_if.hi), 64'hAAAA_5555);
    chk("mtlo busy", 64'(u_if.busy), 64'd0);
    chk("mtlo done", 64'(u_if.done), 64'd0);

    // NOP op leaves HI/LO alone.
    u_if.start = 1'b1;
    u_if.op    = 3'd6;
    u_if.a     = 32'hDEAD_BEEF;
    @(negedge cp);
    u_if.start = 1'b0;
    chk("nop hi", 64'(u_if.hi), 64'hAAAA_5555);
    chk("nop busy", 64'(u_if.busy), 64'd0);

    // MTHI during busy must be ignored.
    do_op("divu_ign", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    // Reset mid-operation.
    @(negedge cp);
    u_if.start = 1'b1;
    u_if.op    = 3'd1;
    u_if.a     = 32'd7;
    u_if.b     = 32'd9;
    @(negedge cp);
    u_if.start = 1'b0;
    repeat (9) @(negedge cp);
    rst = 1'b1;
    @(negedge cp);
    rst = 1'b0;
    chk("midrst busy", 64'(u_if.busy), 64'd0);
    chk("midrst done", 64'(u_if.done), 64'd0);
    chk("midrst hi", 64'(u_if.hi), 64'd0);
    chk("midrst lo", 64'(u_if.lo), 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge cp);
      if (u_if.done) done_seen++;
    end
    chk("midrst late_done", 64'(done_seen), 64'd0);

    do_op("multu_7x9", 3'd1, 32'd7, 32'd9, 32'd0, 32'd63, 0);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative MIPS multiply/divide unit with its own HI/LO result registers.
- Sits directly downstream of the 2-read/1-write register file in the execute stage. Operand a comes from read port 1 (rs) and operand b from read port 2 (rt).
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes hi/lo for MFHI/MFLO. Asserts busy so control can stall dependent instructions.

Parameters:
- W, 32, operand width and width of each of HI and LO.

Ports:
- cp  input  1  clock; all state changes on posedge cp.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on posedge cp.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are NOP.
- a  input  W  operand rs (dividend / multiplicand / MTHI-MTLO data).
- b  input  W  operand rt (divisor / multiplier).
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse when HI/LO have just been updated by MULT/MULTU/DIV/DIVU.
- hi  output  W  HI register.
- lo  output  W  LO register.

Behaviour:
- Interface fixed: one clock cp; reset rst is synchronous and active-high.
- Reset: on a posedge with rst=1, the unit returns to IDLE and busy=0, done=0, hi=0, lo=0.
  - rst overrides start and any in-flight operation; partial results are discarded.
- States:
  - IDLE: start accepted only here (busy=0).
  - RUN: W iteration cycles.
  - FIX: 1 cycle; sign correction and result commit.
- Accept: at an edge with start=1, busy=0, rst=0.
  - op 0-3: latch a and b into internal operand registers, clear the iteration counter, go to RUN.
  - op 4 (MTHI): hi<=a at that edge; stay IDLE; done stays 0.
  - op 5 (MTLO): lo<=a at that edge; stay IDLE; done stays 0.
  - op 6-7: no effect.
- start while busy=1 is ignored entirely; no queueing and no effect on the current operation.
- Signed ops (MULT, DIV): operands are converted to magnitudes at accept and the result signs are recorded.
  - Product sign = sign(a) xor sign(b).
  - Quotient sign = sign(a) xor sign(b).
  - Remainder sign = sign(a).
- Multiply: one shift-add step per RUN cycle, using a 2W-bit accumulator.
- Divide: one restoring shift-subtract step per RUN cycle; yields a W-bit quotient and a W-bit remainder.
- RUN lasts exactly W cycles, counted by an internal counter of width clog2(W)+1; then go to FIX.
- FIX: apply two's-complement negation where the recorded signs require it, then commit at the edge leaving FIX.
  - Multiply: hi<=product[2W-1:W], lo<=product[W-1:0].
  - Divide: lo<=quotient, hi<=remainder.
  - Return to IDLE.
- Timing (accept edge = T0):
  - busy=1 from T0 to T0+W+1 (W+1 cycles).
  - hi/lo change at edge T0+W+1.
  - done=1 for the single cycle after T0+W+1; busy=0 in that same cycle.
  - A new start is legal in the done cycle.
- hi/lo hold their previous values throughout RUN/FIX; MFHI/MFLO during busy returns the old values, and stalling is control's responsibility.
- Divide by zero (b=0), DIV or DIVU: lo<=all-ones, hi<=a (unmodified original dividend). Full latency still applies.
- DIV overflow, a=0x80000000 and b=0xFFFFFFFF (W=32): lo<=0x80000000, hi<=0. No exception.
- Arithmetic is mod 2^W per register; there are no other flags.

Test Plan:
- rst pulse, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF:
  - busy high for 33 cycles.
  - done pulses at cycle 34.
  - hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV and DIVU:
  - DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=100 b=7 -> lo=14, hi=2.
- Boundary divides:
  - DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678.
  - DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0xAAAA5555, then MTLO a=0x1234 on consecutive cycles:
  - hi and lo update at their respective edges; busy and done stay 0.
  - Then start DIVU; during busy, assert start with op=MTHI, a=0 -> ignored; final hi = remainder.
- Reset mid-operation:
  - start MULTU 7*9, assert rst at cycle 10 -> next cycle busy=0, done=0, hi=lo=0, and no late done pulse.
  - Then MULTU 7*9 -> lo=63, hi=0.
